// File: rtl/fan_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fan_pkg : shared speed encodings and PWM constants for the fan controller
// rev 1.0
// ---------------------------------------------------------------------------
package fan_pkg;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_LOW  = 2'd1,
    SPD_MID  = 2'd2,
    SPD_HIGH = 2'd3
  } speed_t;

  localparam int PWM_PERIOD = 1000;
  localparam int PWM_W      = 10;

  // Speed button sequence: OFF->LOW->MID->HIGH->LOW
  function automatic speed_t next_speed(input speed_t cur);
    case (cur)
      SPD_OFF:  next_speed = SPD_LOW;
      SPD_LOW:  next_speed = SPD_MID;
      SPD_MID:  next_speed = SPD_HIGH;
      default:  next_speed = SPD_LOW;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fan_speed_timer_ctrl_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen : prescaler producing a 1-cycle tick every TICK_DIV enabled clocks
// rev 1.0
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Tick is the terminal count of an enabled prescaler
  assign tick = en && (count == LAST);

  // Prescaler: clear wins over counting, counts only while enabled
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fan_speed_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fan_speed_timer_ctrl : speed FSM, PWM counter, auto-off timer, fan drive
// rev 1.0
// ---------------------------------------------------------------------------
module fan_speed_timer_ctrl
  import fan_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int TIMER_STEP = 3,
  parameter int TIMER_MAX  = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_btn_speed,
  input  logic             i_btn_timer,
  input  logic             i_btn_off,
  input  logic             i_fan_1,
  input  logic             i_fan_2,
  input  logic             i_fan_3,
  output logic [PWM_W-1:0] o_pwm_counter,
  output logic             o_fan,
  output logic [1:0]       o_speed,
  output logic [3:0]       o_timer_remain
);

  localparam logic [PWM_W-1:0] CNT_LAST  = PWM_W'(PWM_PERIOD - 1);
  localparam logic [3:0]       REM_MAX   = 4'(TIMER_MAX);
  localparam logic [4:0]       REM_STEP  = 5'(TIMER_STEP);

  speed_t           state;
  logic [PWM_W-1:0] counter;
  logic             fan;
  logic [3:0]       remain;

  logic       tick;
  logic       press;
  logic       expire;
  logic       going_off;
  logic       presc_clr;
  logic       timer_en;
  logic [4:0] sum;
  logic [3:0] remain_pressed;

  // A press in OFF is ignored; a press on a tick edge discards the tick
  assign press     = i_btn_timer && (state != SPD_OFF);
  assign expire    = tick && (remain == 4'd1) && !press;
  assign going_off = i_btn_off || expire;
  assign presc_clr = press || going_off;
  assign timer_en  = (remain != 4'd0);

  // Saturating add, with a press at the maximum wrapping to disabled
  always_comb begin
    sum = {1'b0, remain} + REM_STEP;
    if (remain == REM_MAX)
      remain_pressed = 4'd0;
    else if (sum > {1'b0, REM_MAX})
      remain_pressed = REM_MAX;
    else
      remain_pressed = sum[3:0];
  end

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (i_clk),
    .reset (i_reset),
    .clr   (presc_clr),
    .en    (timer_en),
    .tick  (tick)
  );

  // Speed FSM, PWM counter, countdown and registered fan drive
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= SPD_OFF;
      counter <= '0;
      fan     <= 1'b0;
      remain  <= 4'd0;
    end else begin
      if (going_off) begin
        state  <= SPD_OFF;
        remain <= 4'd0;
      end else begin
        if (i_btn_speed)
          state <= next_speed(state);
        if (press)
          remain <= remain_pressed;
        else if (tick)
          remain <= remain - 4'd1;
      end

      if (going_off || state == SPD_OFF)
        counter <= '0;
      else
        counter <= (counter == CNT_LAST) ? '0 : counter + 1'b1;

      case (state)
        SPD_LOW:  fan <= i_fan_1;
        SPD_MID:  fan <= i_fan_2;
        SPD_HIGH: fan <= i_fan_3;
        default:  fan <= 1'b0;
      endcase
    end
  end

  assign o_pwm_counter  = counter;
  assign o_fan          = fan;
  assign o_speed        = state;
  assign o_timer_remain = remain;

endmodule
`default_nettype wire

// File: tb/tb_fan_speed_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fan_speed_timer_ctrl : directed self-checking bench for the fan controller
// rev 1.0
// ---------------------------------------------------------------------------
module tb_fan_speed_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_speed;
  logic       btn_timer;
  logic       btn_off;
  logic       fan_1;
  logic       fan_2;
  logic       fan_3;
  logic [9:0] pwm_counter;
  logic       fan;
  logic [1:0] speed;
  logic [3:0] timer_remain;

  int checks;
  int errors;
  int exp_cnt;

  fan_speed_timer_ctrl #(
    .TICK_DIV   (10),
    .TIMER_STEP (3),
    .TIMER_MAX  (9)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_btn_speed    (btn_speed),
    .i_btn_timer    (btn_timer),
    .i_btn_off      (btn_off),
    .i_fan_1        (fan_1),
    .i_fan_2        (fan_2),
    .i_fan_3        (fan_3),
    .o_pwm_counter  (pwm_counter),
    .o_fan          (fan),
    .o_speed        (speed),
    .o_timer_remain (timer_remain)
  );

  // Duty comparator for thresholds 222/444/666 of the 1000-count period
  assign fan_1 = (pwm_counter < 10'd222);
  assign fan_2 = (pwm_counter < 10'd444);
  assign fan_3 = (pwm_counter < 10'd666);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle button pulse; mask bit0=speed, bit1=timer, bit2=off.
  // Returns at the negedge after the edge that sampled the pulse.
  task automatic pulse(input int mask);
    @(negedge clk);
    btn_speed = mask[0];
    btn_timer = mask[1];
    btn_off   = mask[2];
    @(negedge clk);
    btn_speed = 1'b0;
    btn_timer = 1'b0;
    btn_off   = 1'b0;
  endtask

  // Advance one cycle while the PWM counter is expected to be running
  task automatic step_track();
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 1000;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (speed !== 2'd0 || pwm_counter !== 10'd0 || fan !== 1'b0 || timer_remain !== 4'd0) begin
      errors++;
      $display("FAIL %s: speed=%0d counter=%0d fan=%0d remain=%0d, required all 0",
               name, speed, pwm_counter, fan, timer_remain);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_asserted");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_all_zero("reset_idle");
    end
  endtask

  // Measure one 1000-cycle window: counter sequence and fan duty
  task automatic measure_window(input string name, input int duty);
    int high;
    int bad;
    high = 0;
    bad  = 0;
    for (int i = 0; i < 1000; i++) begin
      step_track();
      if (pwm_counter !== exp_cnt[9:0]) bad++;
      if (fan === 1'b1) high++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_counter: %0d cycles off sequence, required 0", name, bad);
    end
    checks++;
    if (high != duty) begin
      errors++;
      $display("FAIL %s_duty: fan high %0d cycles, required %0d", name, high, duty);
    end
  endtask

  task automatic test_speed_low();
    pulse(1);
    exp_cnt = 0;
    checks++;
    if (speed !== 2'd1 || pwm_counter !== 10'd0) begin
      errors++;
      $display("FAIL low_entry: speed=%0d counter=%0d, required 1 and 0", speed, pwm_counter);
    end
    measure_window("low_w1", 222);
    measure_window("low_w2", 222);
  endtask

  task automatic test_speed_cycle();
    int exp_spd [3] = '{2, 3, 1};
    int exp_duty[3] = '{444, 666, 222};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_cnt = (exp_cnt + 1) % 1000;
      btn_speed = 1'b1;
      step_track();
      btn_speed = 1'b0;
      checks++;
      if (speed !== exp_spd[k][1:0] || pwm_counter !== exp_cnt[9:0]) begin
        errors++;
        $display("FAIL speed_step%0d: speed=%0d counter=%0d, required %0d and %0d",
                 k, speed, pwm_counter, exp_spd[k], exp_cnt);
      end
      measure_window($sformatf("speed_step%0d", k), exp_duty[k]);
    end
  endtask

  task automatic test_timer_expiry();
    pulse(1);
    checks++;
    if (speed !== 2'd2) begin
      errors++;
      $display("FAIL mid_entry: speed=%0d, required 2", speed);
    end
    pulse(2);
    checks++;
    if (timer_remain !== 4'd3) begin
      errors++;
      $display("FAIL timer_press: remain=%0d, required 3", timer_remain);
    end
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      if (k == 9 || k == 10 || k == 20 || k == 30) begin
        int want;
        want = (k == 9) ? 3 : (k == 10) ? 2 : (k == 20) ? 1 : 0;
        checks++;
        if (timer_remain !== want[3:0]) begin
          errors++;
          $display("FAIL countdown_%0d: remain=%0d, required %0d", k, timer_remain, want);
        end
      end
      if (k == 29) begin
        checks++;
        if (speed !== 2'd2) begin
          errors++;
          $display("FAIL pre_expiry: speed=%0d, required 2", speed);
        end
      end
      if (k == 30) begin
        checks++;
        if (speed !== 2'd0) begin
          errors++;
          $display("FAIL expiry_off: speed=%0d, required 0", speed);
        end
      end
      if (k == 31) begin
        checks++;
        if (pwm_counter !== 10'd0 || fan !== 1'b0) begin
          errors++;
          $display("FAIL after_expiry: counter=%0d fan=%0d, required 0 and 0", pwm_counter, fan);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_rem[4] = '{3, 6, 9, 0};
    pulse(1);
    for (int k = 0; k < 4; k++) begin
      pulse(2);
      checks++;
      if (timer_remain !== exp_rem[k][3:0]) begin
        errors++;
        $display("FAIL timer_b2b%0d: remain=%0d, required %0d", k, timer_remain, exp_rem[k]);
      end
    end
    repeat (30) @(negedge clk);
    checks++;
    if (speed !== 2'd1 || timer_remain !== 4'd0) begin
      errors++;
      $display("FAIL timer_disabled_hold: speed=%0d remain=%0d, required 1 and 0", speed, timer_remain);
    end
    pulse(4);
    checks++;
    if (speed !== 2'd0) begin
      errors++;
      $display("FAIL off_button: speed=%0d, required 0", speed);
    end
    pulse(2);
    checks++;
    if (timer_remain !== 4'd0) begin
      errors++;
      $display("FAIL timer_in_off: remain=%0d, required 0", timer_remain);
    end
  endtask

  task automatic test_off_and_reset();
    pulse(5);
    checks++;
    if (speed !== 2'd0) begin
      errors++;
      $display("FAIL off_speed_from_off: speed=%0d, required 0", speed);
    end
    pulse(1);
    pulse(1);
    pulse(5);
    checks++;
    if (speed !== 2'd0 || pwm_counter !== 10'd0) begin
      errors++;
      $display("FAIL off_speed_from_mid: speed=%0d counter=%0d, required 0 and 0", speed, pwm_counter);
    end
    // Countdown at 6, part-way through a PWM period, then reset
    pulse(1);
    pulse(2);
    pulse(2);
    repeat (25) @(negedge clk);
    checks++;
    if (timer_remain !== 4'd4 || speed !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset: remain=%0d speed=%0d, required 4 and 1", timer_remain, speed);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_mid_countdown");
    // Leftover prescaler/timer state must not reappear after reset
    pulse(1);
    repeat (20) @(negedge clk);
    checks++;
    if (timer_remain !== 4'd0 || speed !== 2'd1 || pwm_counter !== 10'd20) begin
      errors++;
      $display("FAIL post_reset_run: remain=%0d speed=%0d counter=%0d, required 0, 1, 20",
               timer_remain, speed, pwm_counter);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    btn_speed = 1'b0;
    btn_timer = 1'b0;
    btn_off   = 1'b0;
    test_reset();
    test_speed_low();
    test_speed_cycle();
    test_timer_expiry();
    test_back_to_back();
    test_off_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
